hazard_stall_ctrl: RTL and testbench
====================================

# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage RV32I core. It detects load-use hazards that forwarding cannot cover and inserts a single bubble. It flushes IF/ID and ID/EX on a taken branch or jump resolved in EX. It freezes the whole pipeline while data memory is not ready, with a watchdog that latches a sticky error. It sits beside the forwarding unit, drives the pipeline-register write-enables and flushes, and the PC write-enable.

## Interface
- WAIT_TIMEOUT, 255: maximum frozen cycles tolerated in MEM_WAIT before ERROR (1..2^16-1).
- CNT_W, 16: width of the performance counters.

- clk  in  1  pipeline clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ID_rs1, ID_rs2  in  5 each  source registers of the instruction in ID.
- ID_useRs1, ID_useRs2  in  1 each  ID instruction actually reads rs1/rs2.
- EX_rd  in  5  destination register of the instruction in EX.
- EX_memRead  in  1  EX instruction is a load.
- EX_redirect  in  1  taken branch or jump resolved in EX.
- MEM_memRead, MEM_memWrite  in  1 each  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_write  out  1  PC register load enable.
- IFID_write, IDEX_write, EXMEM_write  out  1 each  pipeline-register enables.
- IFID_flush, IDEX_bubble  out  1 each  clear IF/ID; load NOP into ID/EX.
- MEMWB_bubble  out  1  load NOP into MEM/WB.
- mem_timeout  out  1  sticky watchdog error.
- state_o  out  2  FSM state: RUN=00, MEM_WAIT=01, ERROR=10.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. Decode outputs combinationally from the state and the current inputs. Register only the state, the wait counter, mem_timeout and the perf counters.
- Default in RUN: all writes 1, all flush/bubble 0.
- memwait = (MEM_memRead | MEM_memWrite) & !dmem_ready.
- loaduse = EX_memRead & EX_rd!=0 & ((EX_rd==ID_rs1 & ID_useRs1) | (EX_rd==ID_rs2 & ID_useRs2)).
- RUN priority is fixed as follows.
  - memwait, highest: freeze. PC_write, IFID_write, IDEX_write, EXMEM_write = 0; MEMWB_bubble = 1; next state MEM_WAIT; wait counter = 1.
  - EX_redirect: IFID_flush = 1 and IDEX_bubble = 1; PC_write = 1 (loads the target). A load-use in the same cycle is discarded, because its ID instruction is squashed.
  - loaduse: PC_write = 0, IFID_write = 0, IDEX_bubble = 1, for exactly one cycle. The next cycle EX holds the bubble, so there is no re-detection. The loaded value then reaches the consumer through the forwarding unit's WB load path.
- MEM_WAIT:
  - While dmem_ready = 0: hold the freeze outputs and increment the wait counter.
  - When dmem_ready = 1: apply the RUN decode (with memwait forced 0) in that same cycle; next state RUN.
  - If the wait counter == WAIT_TIMEOUT and dmem_ready = 0: next state ERROR.
  - EX_redirect arriving during the freeze stays held in the frozen EX stage and takes effect in the release cycle.
- ERROR: freeze outputs permanently. mem_timeout = 1. Exit only by rst_n.
- Reset (async, at any time, including mid-MEM_WAIT): state = RUN, wait counter = 0, mem_timeout = 0, counters = 0. Outputs then follow the RUN decode of the live inputs.

## Timing
- Hazard and redirect responses are zero-latency (same cycle as the input condition).
- Load-use costs exactly 1 bubble cycle. A redirect costs 2 squashed instructions. A memory wait of N cycles with dmem_ready low costs N frozen cycles.
- Watchdog: ERROR is entered on the edge after WAIT_TIMEOUT consecutive frozen cycles. mem_timeout is visible one cycle later than the last frozen cycle counted.
- The wait counter is 16 bits and never wraps before the timeout comparison.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every load-use bubble cycle and every frozen cycle (MEM_WAIT and the entry cycle).
  - flush_cnt increments on every accepted redirect.
  - Both counters saturate at all-ones.
- HAZARD_PERF_CNT_EN undefined: the counters are not built; stall_cnt and flush_cnt are tied to 0. Ports are kept.

## Test plan
- Load-use: EX_memRead=1, EX_rd=5, ID_rs2=5, ID_useRs2=1 for one cycle -> PC_write=0, IFID_write=0, IDEX_bubble=1 that cycle only; stall_cnt=1.
- EX_rd=0 or ID_useRs1=ID_useRs2=0 with matching registers -> no stall.
- Redirect plus load-use in the same cycle -> IFID_flush=1, IDEX_bubble=1, PC_write=1; flush_cnt=1, stall_cnt=0.
- MEM_memRead=1, dmem_ready=0 for 3 cycles then 1 -> freeze for 3 cycles, state_o=01; release on the 4th cycle; state_o=00 after; stall_cnt=3.
- WAIT_TIMEOUT=4, dmem_ready held 0 -> state_o=10 after 4 frozen cycles; mem_timeout=1; outputs stay frozen. rst_n pulsed low -> state_o=00, mem_timeout=0, counters 0.
- Reset asserted mid-MEM_WAIT -> state_o=00 immediately (async); PC_write follows the live RUN decode.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubble, EX redirect flush, data-memory freeze with watchdog.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_useRs1,
  input  logic             ID_useRs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_memRead,
  input  logic             EX_redirect,
  input  logic             MEM_memRead,
  input  logic             MEM_memWrite,
  input  logic             dmem_ready,
  output logic             PC_write,
  output logic             IFID_write,
  output logic             IDEX_write,
  output logic             EXMEM_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             MEMWB_bubble,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  localparam logic [15:0] TIMEOUT = 16'(WAIT_TIMEOUT);

  state_t      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] wait_inc;
  logic        mem_timeout_q, mem_timeout_d;

  logic memwait;
  logic loaduse;
  logic freeze;
  logic run_decode;
  logic redirect_go;
  logic loaduse_go;

  assign memwait = (MEM_memRead | MEM_memWrite) & ~dmem_ready;
  assign loaduse = EX_memRead & (EX_rd != 5'd0) &
                   (((EX_rd == ID_rs1) & ID_useRs1) | ((EX_rd == ID_rs2) & ID_useRs2));

  // Freeze covers the MEM_WAIT entry cycle, every waiting cycle and the terminal error state.
  assign freeze = ((state_q == ST_RUN) & memwait) |
                  ((state_q == ST_MEM_WAIT) & ~dmem_ready) |
                  (state_q == ST_ERROR);
  assign run_decode  = ~freeze;
  assign redirect_go = run_decode & EX_redirect;
  assign loaduse_go  = run_decode & ~EX_redirect & loaduse;
  assign wait_inc    = wait_cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= 16'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // The compared value includes the current frozen cycle, so ERROR follows exactly WAIT_TIMEOUT of them.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      ST_RUN: begin
        if (memwait) begin
          wait_cnt_d = 16'd1;
          if (TIMEOUT == 16'd1) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            state_d = ST_MEM_WAIT;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == TIMEOUT) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  always_comb begin
    PC_write     = 1'b1;
    IFID_write   = 1'b1;
    IDEX_write   = 1'b1;
    EXMEM_write  = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    MEMWB_bubble = 1'b0;
    if (freeze) begin
      PC_write     = 1'b0;
      IFID_write   = 1'b0;
      IDEX_write   = 1'b0;
      EXMEM_write  = 1'b0;
      MEMWB_bubble = 1'b1;
    end else if (redirect_go) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (loaduse_go) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_bubble = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_evt;

  assign stall_evt = loaduse_go | (freeze & (state_q != ST_ERROR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_go && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with WAIT_TIMEOUT=4; counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_useRs1, ID_useRs2, EX_memRead, EX_redirect;
  logic        MEM_memRead, MEM_memWrite, dmem_ready;
  logic        PC_write, IFID_write, IDEX_write, EXMEM_write;
  logic        IFID_flush, IDEX_bubble, MEMWB_bubble, mem_timeout;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  hazard_stall_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_useRs1(ID_useRs1), .ID_useRs2(ID_useRs2),
    .EX_rd(EX_rd), .EX_memRead(EX_memRead), .EX_redirect(EX_redirect),
    .MEM_memRead(MEM_memRead), .MEM_memWrite(MEM_memWrite), .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .MEMWB_bubble(MEMWB_bubble), .mem_timeout(mem_timeout), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic int perf_exp(input int n);
    return (PERF != 0) ? n : 0;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: got=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_useRs1 = 1'b0; ID_useRs2 = 1'b0;
    EX_rd = 5'd0; EX_memRead = 1'b0; EX_redirect = 1'b0;
    MEM_memRead = 1'b0; MEM_memWrite = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_pc_write", 32'(PC_write), 32'd1);
    check_val("rst_timeout", 32'(mem_timeout), 32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    do_reset();

    // load-use via rs2
    EX_memRead = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_useRs2 = 1'b1;
    #1;
    check_val("lu_pc_write", 32'(PC_write), 32'd0);
    check_val("lu_ifid_write", 32'(IFID_write), 32'd0);
    check_val("lu_idex_bubble", 32'(IDEX_bubble), 32'd1);
    check_val("lu_idex_write", 32'(IDEX_write), 32'd1);
    check_val("lu_flush", 32'(IFID_flush), 32'd0);
    step();
    clear_inputs();
    #1;
    check_val("lu_after_pc", 32'(PC_write), 32'd1);
    check_val("lu_after_bubble", 32'(IDEX_bubble), 32'd0);
    check_val("lu_stall_cnt", 32'(stall_cnt), 32'(perf_exp(1)));

    // no stall cases
    EX_memRead = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_useRs1 = 1'b1;
    #1;
    check_val("rd0_pc_write", 32'(PC_write), 32'd1);
    EX_rd = 5'd7; ID_rs1 = 5'd7; ID_rs2 = 5'd7; ID_useRs1 = 1'b0; ID_useRs2 = 1'b0;
    #1;
    check_val("nouse_pc_write", 32'(PC_write), 32'd1);
    check_val("nouse_bubble", 32'(IDEX_bubble), 32'd0);
    ID_useRs1 = 1'b1;
    #1;
    check_val("rs1_lu_bubble", 32'(IDEX_bubble), 32'd1);
    step();
    clear_inputs();

    // redirect plus load-use
    do_reset();
    EX_redirect = 1'b1; EX_memRead = 1'b1; EX_rd = 5'd9; ID_rs1 = 5'd9; ID_useRs1 = 1'b1;
    #1;
    check_val("rd_ifid_flush", 32'(IFID_flush), 32'd1);
    check_val("rd_idex_bubble", 32'(IDEX_bubble), 32'd1);
    check_val("rd_pc_write", 32'(PC_write), 32'd1);
    step();
    clear_inputs();
    #1;
    check_val("rd_flush_cnt", 32'(flush_cnt), 32'(perf_exp(1)));
    check_val("rd_stall_cnt", 32'(stall_cnt), 32'd0);

    // memory wait of 3 cycles, redirect held during freeze
    do_reset();
    MEM_memRead = 1'b1; dmem_ready = 1'b0;
    #1;
    check_val("mw1_state", 32'(state_o), 32'd0);
    check_val("mw1_pc_write", 32'(PC_write), 32'd0);
    check_val("mw1_exmem_write", 32'(EXMEM_write), 32'd0);
    check_val("mw1_memwb_bubble", 32'(MEMWB_bubble), 32'd1);
    step();
    EX_redirect = 1'b1;
    #1;
    check_val("mw2_state", 32'(state_o), 32'd1);
    check_val("mw2_flush_held", 32'(IFID_flush), 32'd0);
    check_val("mw2_idex_write", 32'(IDEX_write), 32'd0);
    step();
    check_val("mw3_pc_write", 32'(PC_write), 32'd0);
    step();
    dmem_ready = 1'b1;
    #1;
    check_val("rel_state", 32'(state_o), 32'd1);
    check_val("rel_pc_write", 32'(PC_write), 32'd1);
    check_val("rel_ifid_flush", 32'(IFID_flush), 32'd1);
    check_val("rel_memwb_bubble", 32'(MEMWB_bubble), 32'd0);
    check_val("rel_exmem_write", 32'(EXMEM_write), 32'd1);
    step();
    clear_inputs();
    #1;
    check_val("post_state", 32'(state_o), 32'd0);
    check_val("mw_stall_cnt", 32'(stall_cnt), 32'(perf_exp(3)));
    check_val("mw_flush_cnt", 32'(flush_cnt), 32'(perf_exp(1)));

    // watchdog with WAIT_TIMEOUT=4
    do_reset();
    MEM_memWrite = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    step();
    check_val("wd4_state", 32'(state_o), 32'd1);
    check_val("wd4_timeout", 32'(mem_timeout), 32'd0);
    step();
    check_val("err_state", 32'(state_o), 32'd2);
    check_val("err_timeout", 32'(mem_timeout), 32'd1);
    check_val("err_pc_write", 32'(PC_write), 32'd0);
    check_val("err_memwb_bubble", 32'(MEMWB_bubble), 32'd1);
    dmem_ready = 1'b1;
    #1;
    check_val("err_ready_pc_write", 32'(PC_write), 32'd0);
    step();
    check_val("err_sticky_state", 32'(state_o), 32'd2);
    check_val("err_stall_cnt", 32'(stall_cnt), 32'(perf_exp(4)));
    rst_n = 1'b0;
    #1;
    check_val("err_rst_state", 32'(state_o), 32'd0);
    check_val("err_rst_timeout", 32'(mem_timeout), 32'd0);
    check_val("err_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("err_rst_pc_write", 32'(PC_write), 32'd1);
    clear_inputs();
    step();
    rst_n = 1'b1;

    // asynchronous reset in the middle of MEM_WAIT
    do_reset();
    MEM_memRead = 1'b1; dmem_ready = 1'b0;
    step();
    step();
    check_val("mid_state", 32'(state_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_state", 32'(state_o), 32'd0);
    check_val("mid_rst_pc_live", 32'(PC_write), 32'd0);
    dmem_ready = 1'b1;
    #1;
    check_val("mid_rst_pc_ready", 32'(PC_write), 32'd1);
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
